// File: rtl/wb_uart_cmd_pkg.sv
// Shared types and ASCII helpers for the UART-to-Wishbone command master.
package wb_uart_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_WDATA,
    GET_RCNT,
    WB_REQ,
    TX_HI,
    TX_LO,
    TX_WAIT,
    TX_STATUS
  } state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SEND,
    T_HOLD,
    T_DRAIN
  } tx_state_e;

  localparam logic [7:0] CH_A    = 8'h41;
  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_K    = 8'h4B;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_BANG = 8'h21;

  // Bit 4 is the valid flag; only uppercase hex is accepted.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

endpackage

// File: rtl/wb_uart_cmd_tx.sv
// Single-byte UART transmit handshake: waits for an idle transmitter,
// strobes the byte, then waits for the transmitter to finish.
module wb_uart_cmd_tx
  import wb_uart_cmd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  output logic       o_done
);

  tx_state_e  state_q, state_d;
  logic [7:0] byte_q, byte_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= T_IDLE;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
    end
  end

  // T_HOLD skips one cycle so the transmitter has time to raise busy.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    o_tx_valid = 1'b0;
    o_done     = 1'b0;
    case (state_q)
      T_IDLE: begin
        if (i_start) begin
          byte_d  = i_byte;
          state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (!i_tx_busy) begin
          o_tx_valid = 1'b1;
          state_d    = T_HOLD;
        end
      end
      T_HOLD:  state_d = T_DRAIN;
      T_DRAIN: begin
        if (!i_tx_busy) begin
          o_done  = 1'b1;
          state_d = T_IDLE;
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

  assign o_tx_data = byte_q;

endmodule

// File: rtl/wb_uart_cmd_master.sv
// ASCII command parser driving Wishbone classic single cycles from a UART.
// Optional bus timeout with '!' response is enabled by WB_TIMEOUT_EN.
module wb_uart_cmd_master
  import wb_uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_DIGITS = 1,
`ifdef WB_TIMEOUT_EN
  parameter int unsigned TIMEOUT     = 255,
`endif
  localparam int unsigned ADDR_W     = 4 * ADDR_DIGITS
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_clear,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_busy,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [7:0]        o_wb_dat,
  input  logic [7:0]        i_wb_dat,
  input  logic              i_wb_ack
);

  localparam logic [7:0] DIG_LAST = 8'(ADDR_DIGITS - 1);

  state_e              state_q, state_d, ret_q, ret_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, acc_q, acc_d;
  logic [7:0]          dig_q, dig_d, wdat_q, wdat_d, rdat_q, rdat_d, status_q, status_d;
  logic [3:0]          rcnt_q, rcnt_d;
  logic                we_q, we_d, armed_q, armed_d, clear_q, clear_d;

  logic                rx_take, tx_start, tx_done;
  logic [7:0]          tx_byte;
  logic [4:0]          nib;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned        TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0]              tmo_q, tmo_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) tmo_q <= '0;
    else            tmo_q <= tmo_d;
  end

  always_comb tmo_d = (state_q == WB_REQ) ? tmo_q + TMO_W'(1) : '0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      ret_q    <= IDLE;
      addr_q   <= '0;
      acc_q    <= '0;
      dig_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      status_q <= '0;
      rcnt_q   <= '0;
      we_q     <= 1'b0;
      armed_q  <= 1'b1;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      dig_q    <= dig_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      status_q <= status_d;
      rcnt_q   <= rcnt_d;
      we_q     <= we_d;
      armed_q  <= armed_d;
      clear_q  <= clear_d;
    end
  end

  // A byte is only taken in parse states and only once per valid-high episode.
  assign rx_take = i_rx_valid && armed_q &&
                   (state_q == IDLE || state_q == GET_ADDR ||
                    state_q == GET_WDATA || state_q == GET_RCNT);
  assign nib = hex2nib(i_rx_data);

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    dig_d    = dig_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    status_d = status_q;
    rcnt_d   = rcnt_q;
    we_d     = we_q;
    armed_d  = armed_q | ~i_rx_valid;
    clear_d  = rx_take;
    tx_start = 1'b0;
    tx_byte  = status_q;
    if (rx_take) armed_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_take) begin
          dig_d = '0;
          acc_d = '0;
          case (i_rx_data)
            CH_A:    state_d = GET_ADDR;
            CH_W:    state_d = GET_WDATA;
            CH_R:    state_d = GET_RCNT;
            default: begin
              status_d = CH_E;
              state_d  = TX_STATUS;
            end
          endcase
        end
      end
      GET_ADDR: begin
        if (rx_take) begin
          if (!nib[4]) begin
            status_d = CH_E;
            state_d  = TX_STATUS;
          end else begin
            acc_d = (acc_q << 4) | ADDR_W'(nib[3:0]);
            dig_d = dig_q + 8'd1;
            if (dig_q == DIG_LAST) begin
              addr_d  = acc_d;
              state_d = IDLE;
            end
          end
        end
      end
      GET_WDATA: begin
        if (rx_take) begin
          if (!nib[4]) begin
            status_d = CH_E;
            state_d  = TX_STATUS;
          end else begin
            wdat_d = {wdat_q[3:0], nib[3:0]};
            dig_d  = dig_q + 8'd1;
            if (dig_q == 8'd1) begin
              we_d    = 1'b1;
              state_d = WB_REQ;
            end
          end
        end
      end
      GET_RCNT: begin
        if (rx_take) begin
          if (!nib[4]) begin
            status_d = CH_E;
            state_d  = TX_STATUS;
          end else begin
            rcnt_d  = nib[3:0];
            we_d    = 1'b0;
            state_d = WB_REQ;
          end
        end
      end
      WB_REQ: begin
        if (i_wb_ack) begin
          if (we_q) begin
            status_d = CH_K;
            state_d  = TX_STATUS;
          end else begin
            rdat_d  = i_wb_dat;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = TX_HI;
          end
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          status_d = CH_BANG;
          state_d  = TX_STATUS;
        end
`endif
      end
      TX_HI: begin
        tx_start = 1'b1;
        tx_byte  = nib2hex(rdat_q[7:4]);
        ret_d    = TX_LO;
        state_d  = TX_WAIT;
      end
      TX_LO: begin
        tx_start = 1'b1;
        tx_byte  = nib2hex(rdat_q[3:0]);
        if (rcnt_q == 4'd0) begin
          ret_d = IDLE;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
          ret_d  = WB_REQ;
        end
        state_d = TX_WAIT;
      end
      TX_STATUS: begin
        tx_start = 1'b1;
        ret_d    = IDLE;
        state_d  = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) state_d = ret_q;
      end
      default: state_d = IDLE;
    endcase
  end

  wb_uart_cmd_tx u_tx (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_start    (tx_start),
    .i_byte     (tx_byte),
    .i_tx_busy  (i_tx_busy),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_done     (tx_done)
  );

  assign o_rx_clear = clear_q;
  assign o_wb_cyc   = (state_q == WB_REQ);
  assign o_wb_stb   = (state_q == WB_REQ);
  assign o_wb_we    = we_q & o_wb_cyc;
  assign o_wb_adr   = addr_q;
  assign o_wb_dat   = wdat_q;

endmodule

// File: tb/tb_wb_uart_cmd_master.sv
// Bench for wb_uart_cmd_master: directed plan plus random command stream
// checked against a string-level command interpreter.
module tb_wb_uart_cmd_master;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       o_rx_clear;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_busy;
  logic       o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0] o_wb_adr;
  logic [7:0] o_wb_dat;
  logic [7:0] i_wb_dat;
  logic       i_wb_ack;

  always #5 i_clk = ~i_clk;

  wb_uart_cmd_master #(.ADDR_DIGITS(1)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_clear (o_rx_clear),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_busy  (i_tx_busy),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_we    (o_wb_we),
    .o_wb_adr   (o_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .i_wb_dat   (i_wb_dat),
    .i_wb_ack   (i_wb_ack)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  slv_mem [16];
  logic [7:0]  m_mem   [16];
  logic [3:0]  m_addr;
  int          slv_lat = 2;
  int          cyc_cnt = 0;
  int          last_len = 0;
  int          cyc_starts = 0;
  logic [7:0]  got_tx[$];
  logic [7:0]  exp_tx[$];
  logic [12:0] got_bus[$];
  logic [12:0] exp_bus[$];
  string       hexs = "0123456789ABCDEF";

  // Wishbone slave: acks in the slv_lat-th cycle of stb (0 = never).
  initial begin
    i_wb_ack = 1'b0;
    i_wb_dat = '0;
    forever begin
      @(negedge i_clk);
      i_wb_ack = 1'b0;
      if (o_wb_cyc && o_wb_stb) begin
        if (cyc_cnt == 0) cyc_starts++;
        cyc_cnt++;
        if (slv_lat != 0 && cyc_cnt == slv_lat) begin
          if (o_wb_we) slv_mem[o_wb_adr] = o_wb_dat;
          else         i_wb_dat = slv_mem[o_wb_adr];
          got_bus.push_back({o_wb_we, o_wb_adr, slv_mem[o_wb_adr]});
          i_wb_ack = 1'b1;
        end
      end else if (cyc_cnt != 0) begin
        last_len = cyc_cnt;
        cyc_cnt  = 0;
      end
    end
  end

  // UART transmitter: busy for a few cycles after each strobe.
  initial begin
    i_tx_busy = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_tx_valid) begin
        got_tx.push_back(o_tx_data);
        @(negedge i_clk);
        i_tx_busy = 1'b1;
        repeat (3) @(negedge i_clk);
        i_tx_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return -1;
  endfunction

  // Interprets a complete command string the way a terminal user would expect.
  task automatic model_cmd(input string s);
    int i, d, v;
    logic [7:0] c;
    bit ok;
    i = 0;
    while (i < s.len()) begin
      c = s[i];
      i++;
      if (c == 8'h41 || c == 8'h57 || c == 8'h52) begin
        int nd;
        nd = (c == 8'h57) ? 2 : 1;
        v  = 0;
        ok = 1'b1;
        for (int k = 0; k < nd; k++) begin
          d = hexval(s[i]);
          i++;
          if (d < 0) begin
            exp_tx.push_back(8'h45);
            ok = 1'b0;
            break;
          end
          v = v * 16 + d;
        end
        if (ok) begin
          if (c == 8'h41) begin
            m_addr = 4'(v);
          end else if (c == 8'h57) begin
            m_mem[m_addr] = 8'(v);
            exp_bus.push_back({1'b1, m_addr, 8'(v)});
            exp_tx.push_back(8'h4B);
          end else begin
            for (int b = 0; b <= v; b++) begin
              exp_bus.push_back({1'b0, m_addr, m_mem[m_addr]});
              exp_tx.push_back(hexs[int'(m_mem[m_addr]) / 16]);
              exp_tx.push_back(hexs[int'(m_mem[m_addr]) % 16]);
              m_addr = m_addr + 4'd1;
            end
          end
        end
      end else begin
        exp_tx.push_back(8'h45);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    n = 0;
    while (!o_rx_clear && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    i_rx_valid = 1'b0;
    chk("rx_accept", 32'(n < 3000), 32'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic run_cmd(input string s);
    int n, starts0;
    got_tx.delete();
    exp_tx.delete();
    got_bus.delete();
    exp_bus.delete();
    starts0 = cyc_starts;
    model_cmd(s);
    send_str(s);
    n = 0;
    while (got_tx.size() < exp_tx.size() && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk({"tx_in_time ", s}, 32'(n < 3000), 32'd1);
    repeat (12) @(negedge i_clk);
    chk({"tx_count ", s}, 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int k = 0; k < exp_tx.size() && k < got_tx.size(); k++)
      chk({"tx_byte ", s}, 32'(got_tx[k]), 32'(exp_tx[k]));
    chk({"bus_count ", s}, 32'(got_bus.size()), 32'(exp_bus.size()));
    for (int k = 0; k < exp_bus.size() && k < got_bus.size(); k++)
      chk({"bus_xfer ", s}, 32'(got_bus[k]), 32'(exp_bus[k]));
    chk({"cyc_starts ", s}, 32'(cyc_starts - starts0), 32'(exp_bus.size()));
    chk({"addr_reg ", s}, 32'(o_wb_adr), 32'(m_addr));
  endtask

  initial begin
    int n;
    string s, errs;
    errs = "Zag?x";
    i_reset_n  = 1'b0;
    i_rx_data  = '0;
    i_rx_valid = 1'b0;
    m_addr     = '0;
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = 8'($urandom);
      m_mem[i]   = slv_mem[i];
    end
    #1;
    chk("reset_outputs", 32'({o_rx_clear, o_tx_valid, o_tx_data, o_wb_cyc, o_wb_stb,
                              o_wb_we, o_wb_adr, o_wb_dat}), 32'd0);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("post_reset_outputs", 32'({o_rx_clear, o_tx_valid, o_wb_cyc, o_wb_adr}), 32'd0);

    slv_mem[1] = 8'h5C; m_mem[1] = 8'h5C;
    run_cmd("A1R0");
    chk("zero_wait_cyc_len", 32'(last_len), 32'd2);

    run_cmd("A3W7F");
    chk("write_mem", 32'(slv_mem[3]), 32'h7F);
    run_cmd("A3R0");

    slv_mem[14] = 8'h11; m_mem[14] = 8'h11;
    slv_mem[15] = 8'h22; m_mem[15] = 8'h22;
    slv_mem[0]  = 8'h33; m_mem[0]  = 8'h33;
    run_cmd("AER2");

    run_cmd("X");
    run_cmd("AG");
    run_cmd("Aa");
    run_cmd("W3g");
    run_cmd("R:");

    slv_lat = 4;
    run_cmd("A1R0");
    chk("wait_state_cyc_len", 32'(last_len), 32'd4);

`ifdef WB_TIMEOUT_EN
    run_cmd("A1");
    slv_lat = 0;
    got_tx.delete();
    send_str("R0");
    n = 0;
    while (got_tx.size() < 1 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    repeat (12) @(negedge i_clk);
    chk("timeout_resp_count", 32'(got_tx.size()), 32'd1);
    if (got_tx.size() > 0) chk("timeout_resp", 32'(got_tx[0]), 32'h21);
    chk("timeout_cyc_len", 32'(last_len), 32'd255);
    chk("timeout_addr_held", 32'(o_wb_adr), 32'd1);
`endif

    // Reset in the middle of a bus cycle.
    run_cmd("A1");
    slv_lat = 0;
    got_tx.delete();
    send_str("R0");
    n = 0;
    while (!o_wb_cyc && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("cyc_before_reset", 32'(o_wb_cyc), 32'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("async_reset_drop", 32'({o_wb_cyc, o_wb_stb, o_tx_valid}), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    m_addr = '0;
    repeat (20) @(negedge i_clk);
    chk("no_resp_after_reset", 32'(got_tx.size()), 32'd0);
    chk("addr_after_reset", 32'(o_wb_adr), 32'd0);
    slv_lat = 2;
    run_cmd("A1R0");

    for (int it = 0; it < 40; it++) begin
      int k;
      slv_lat = int'($urandom_range(1, 3));
      k = int'($urandom_range(0, 9));
      if (k <= 2) begin
        n = int'($urandom_range(0, 15));
        s = {"A", hexs.substr(n, n)};
      end else if (k <= 5) begin
        n = int'($urandom_range(0, 255));
        s = {"W", hexs.substr(n / 16, n / 16), hexs.substr(n % 16, n % 16)};
      end else if (k <= 8) begin
        n = int'($urandom_range(0, 3));
        s = {"R", hexs.substr(n, n)};
      end else begin
        n = int'($urandom_range(0, 4));
        s = errs.substr(n, n);
        if ($urandom_range(0, 1) == 1) s = {"A", s};
      end
      run_cmd(s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
